// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapaths: controller
// state encoding and the counter-width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/one_bit_full_subtractor.sv
// One-bit full subtractor cell: diff = i0 - i1 - bin, with borrow-out.
// Companion of the one-bit full adder cell; purely combinational.
module one_bit_full_subtractor (
    input  logic i0,
    input  logic i1,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = i0 ^ i1 ^ bin;
    assign bout = (~i0 & i1) | (~(i0 ^ i1) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (i0 - i1 - bin), LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flop.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_diff;
    logic             cell_bout;

    one_bit_full_subtractor u_cell (
        .i0   (a_q[0]),
        .i1   (b_q[0]),
        .bin  (br_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            // DONE accepts a new start exactly like IDLE, so back-to-back
            // operations lose no cycle.
            IDLE, DONE: begin
                if (start) begin
                    a_d     = i0;
                    b_d     = i1;
                    br_d    = bin;
                    r_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                r_d   = {cell_diff, r_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = cell_bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {cell_diff, r_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results with
// their due cycle; a negedge monitor checks done/busy/diff/bout every cycle.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    typedef struct {
        logic [W:0]  res;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    logic [W:0]  last_res;
    int unsigned cyc;
    int unsigned busy_until;
    int          checks;
    int          errors;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .i0    (i0),
        .i1    (i1),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    // Monitor: an accepted op completes exactly W edges after acceptance;
    // outputs otherwise hold the most recent completed result.
    always @(negedge clk) begin
        logic exp_done;
        if (!rst_n) begin
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_done", {31'b0, done}, 32'd0);
            chk("rst_diff", {{(32-W){1'b0}}, diff}, 32'd0);
            chk("rst_bout", {31'b0, bout}, 32'd0);
        end else begin
            exp_done = (q.size() > 0) && (q[0].due == cyc);
            if (exp_done) begin
                last_res = q[0].res;
                void'(q.pop_front());
            end
            chk("done", {31'b0, done}, {31'b0, exp_done});
            chk("busy", {31'b0, busy}, {31'b0, (q.size() > 0)});
            chk("diff", {{(32-W){1'b0}}, diff}, {{(32-W){1'b0}}, last_res[W-1:0]});
            chk("bout", {31'b0, bout}, {31'b0, last_res[W]});
        end
    end

    // Called at posedge+1; waits until the DUT is in IDLE/DONE, then issues.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t e;
        while (cyc < busy_until) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        i0 = a;
        i1 = b;
        bin = bi;
        @(posedge clk); #1;
        e.res = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        e.due = cyc + W;
        q.push_back(e);
        busy_until = e.due;
        start = 1'b0;
        i0 = W'($urandom);
        i1 = W'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Start and operand noise while shifting; must not affect anything.
    task automatic glitch();
        start = 1'b1;
        i0 = W'($urandom);
        i1 = W'($urandom);
        bin = 1'($urandom);
        idle(2);
        start = 1'b0;
    endtask

    task automatic mid_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        start = 1'b0;
        q.delete();
        last_res = '0;
        busy_until = 0;
        #5;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        last_res = '0;
        busy_until = 0;
        rst_n = 1'b0;
        start = 1'b0;
        i0 = '0;
        i1 = '0;
        bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Directed cases
        issue(4'd9, 4'd3, 1'b0);
        idle(W + 2);
        issue(4'd3, 4'd9, 1'b0);
        issue(4'd0, 4'd0, 1'b1);
        issue(4'd15, 4'd15, 1'b0);
        issue(4'd9, 4'd3, 1'b0);
        issue(4'd5, 4'd2, 1'b0);     // back-to-back from DONE
        issue(4'd12, 4'd7, 1'b1);
        glitch();
        idle(W + 2);

        // Reset mid-operation, then a fresh start
        issue(4'd6, 4'd1, 1'b0);
        idle(1);
        mid_reset();
        idle(W + 2);
        issue(4'd10, 4'd4, 1'b1);
        idle(W + 2);

        // Exhaustive sweep with random gaps and noise
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    issue(W'(a), W'(b), 1'(c));
                    if ($urandom_range(0, 7) == 0) glitch();
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, W + 2));
                end

        // Random ops with occasional mid-op reset
        for (int n = 0; n < 100; n++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                idle($urandom_range(0, W - 2));
                mid_reset();
            end
        end

        idle(W + 3);
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
